// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_frame_scheduler                                         |
// | Description : Arbitrates a UART byte stream between snapshot frames        |
// |               (counter + 13 payload bytes [+ checksum] + trailer) and      |
// |               single-byte messages, with round-robin tie breaking.         |
// | Options     : define FRAME_CHECKSUM_EN to insert an XOR checksum byte      |
// |               ahead of the trailer (16-byte frame instead of 15).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_frame_scheduler #(
  parameter logic [7:0] TRAILER_BYTE = 8'hBB
) (
  input  logic         Sys_CLK,
  input  logic         Sys_RST,
  input  logic         frameTrig,
  input  logic [7:0]   frameCounter,
  input  logic [103:0] framePayload,
  input  logic         msgValid,
  input  logic [7:0]   msgData,
  output logic         msgReady,
  output logic [7:0]   TxData,
  output logic         TxData_valid,
  input  logic         TxData_ready,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    MSG   = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_FRAME = 1'b0,
    GRANT_MSG   = 1'b1
  } grant_t;

`ifdef FRAME_CHECKSUM_EN
  localparam logic [3:0] c_LAST_IDX = 4'd15;
`else
  localparam logic [3:0] c_LAST_IDX = 4'd14;
`endif

  state_t         r_state;
  state_t         w_state_next;
  grant_t         r_last_grant;
  logic           r_trig_q;
  logic           r_trig_primed;
  logic           r_frame_pending;
  logic           r_overrun;
  logic [7:0]     r_snap_cnt;
  logic [103:0]   r_snap_pay;
  logic [3:0]     r_byte_idx;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;

  logic           w_trig_edge;
  logic           w_grant_frame;
  logic           w_grant_msg;
  logic           w_xfer;
  logic           w_last_xfer;
  logic [3:0]     w_idx_next;
  logic [7:0]     w_frame_byte [0:15];

  // The first edge after reset only loads r_trig_q, so a static level is not a request.
  assign w_trig_edge   = r_trig_primed && (frameTrig != r_trig_q);

  // Grants happen only from IDLE; on a tie the source not served last wins.
  assign w_grant_frame = (r_state == IDLE) && r_frame_pending &&
                         (!msgValid || (r_last_grant == GRANT_MSG));
  assign w_grant_msg   = (r_state == IDLE) && msgValid &&
                         (!r_frame_pending || (r_last_grant == GRANT_FRAME));

  assign w_xfer        = r_tx_valid && TxData_ready;
  assign w_last_xfer   = w_xfer && ((r_state == MSG) ||
                                    ((r_state == FRAME) && (r_byte_idx == c_LAST_IDX)));
  // Byte index saturates at the last byte rather than wrapping.
  assign w_idx_next    = (r_byte_idx == c_LAST_IDX) ? r_byte_idx : (r_byte_idx + 4'd1);

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] w_checksum;

  // XOR of the snapshot counter and all 13 payload bytes.
  always_comb begin
    w_checksum = r_snap_cnt;
    for (int i = 0; i < 13; i++) begin
      w_checksum = w_checksum ^ r_snap_pay[8*i +: 8];
    end
  end
`endif

  // Frame byte table built from the snapshot; unused tail slots read as trailer.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_frame_byte[i] = TRAILER_BYTE;
    end
    w_frame_byte[0] = r_snap_cnt;
    for (int i = 0; i < 13; i++) begin
      w_frame_byte[i+1] = r_snap_pay[103-8*i -: 8];
    end
`ifdef FRAME_CHECKSUM_EN
    w_frame_byte[14] = w_checksum;
`endif
  end

  // State register.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and message handshake; a transaction ends only on its final transfer.
  always_comb begin
    w_state_next = r_state;
    msgReady     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_frame) begin
          w_state_next = FRAME;
        end else if (w_grant_msg) begin
          w_state_next = MSG;
          msgReady     = 1'b1;
        end
      end
      FRAME, MSG: begin
        if (w_last_xfer) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Trigger edge detection, pending request and sticky overrun tracking.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      r_trig_q        <= 1'b0;
      r_trig_primed   <= 1'b0;
      r_frame_pending <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_trig_q      <= frameTrig;
      r_trig_primed <= 1'b1;
      if (w_grant_frame) begin
        // A new edge arriving with the grant re-arms the request instead of being lost.
        r_frame_pending <= w_trig_edge;
      end else if (w_trig_edge) begin
        r_frame_pending <= 1'b1;
        if (r_frame_pending) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  // Output byte register, snapshot capture and frame sequencing.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      r_tx_data    <= TRAILER_BYTE;
      r_tx_valid   <= 1'b0;
      r_byte_idx   <= 4'd0;
      r_last_grant <= GRANT_MSG;
      r_snap_cnt   <= 8'd0;
      r_snap_pay   <= 104'd0;
    end else if (w_grant_frame) begin
      r_snap_cnt   <= frameCounter;
      r_snap_pay   <= framePayload;
      r_byte_idx   <= 4'd0;
      r_tx_data    <= frameCounter;
      r_tx_valid   <= 1'b1;
      r_last_grant <= GRANT_FRAME;
    end else if (w_grant_msg) begin
      r_tx_data    <= msgData;
      r_tx_valid   <= 1'b1;
      r_last_grant <= GRANT_MSG;
    end else if (w_last_xfer) begin
      r_tx_valid   <= 1'b0;
    end else if (w_xfer && (r_state == FRAME)) begin
      r_byte_idx   <= w_idx_next;
      r_tx_data    <= w_frame_byte[w_idx_next];
    end
  end

  assign TxData       = r_tx_data;
  assign TxData_valid = r_tx_valid;
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_frame_scheduler                                      |
// | Description : Directed self-checking bench for uart_frame_scheduler.       |
// |               Honours FRAME_CHECKSUM_EN for the expected frame tables.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_frame_scheduler;

`ifdef FRAME_CHECKSUM_EN
  localparam int c_LEN = 16;
`else
  localparam int c_LEN = 15;
`endif

  logic         Sys_CLK = 1'b0;
  logic         Sys_RST;
  logic         frameTrig;
  logic [7:0]   frameCounter;
  logic [103:0] framePayload;
  logic         msgValid;
  logic [7:0]   msgData;
  logic         msgReady;
  logic [7:0]   TxData;
  logic         TxData_valid;
  logic         TxData_ready;
  logic         busy;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_a [16];
  logic [7:0] exp_f [16];

  uart_frame_scheduler #(.TRAILER_BYTE(8'hBB)) dut (
    .Sys_CLK      (Sys_CLK),
    .Sys_RST      (Sys_RST),
    .frameTrig    (frameTrig),
    .frameCounter (frameCounter),
    .framePayload (framePayload),
    .msgValid     (msgValid),
    .msgData      (msgData),
    .msgReady     (msgReady),
    .TxData       (TxData),
    .TxData_valid (TxData_valid),
    .TxData_ready (TxData_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Sys_CLK);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (TxData_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk1(tag, TxData_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (TxData_valid !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk1(tag, TxData_valid, 1'b0);
  endtask

  // Checks c_LEN back-to-back bytes starting at the byte currently presented.
  task automatic check_frame(input string tag, input logic [7:0] e [16]);
    for (int k = 0; k < c_LEN; k++) begin
      chk8($sformatf("%s_byte%0d", tag, k), TxData, e[k]);
      chk1($sformatf("%s_valid%0d", tag, k), TxData_valid, 1'b1);
      tick();
    end
    chk1({tag, "_end_valid"}, TxData_valid, 1'b0);
  endtask

  initial begin
`ifdef FRAME_CHECKSUM_EN
    exp_a = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h04, 8'hBB};
    exp_f = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hBB};
`else
    exp_a = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hBB, 8'h00};
    exp_f = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBB, 8'h00};
`endif

    // Reset with frameTrig already high: must not count as a request later.
    Sys_RST      = 1'b0;
    frameTrig    = 1'b1;
    frameCounter = 8'h05;
    framePayload = 104'h0102030405060708090A0B0C0D;
    msgValid     = 1'b0;
    msgData      = 8'h00;
    TxData_ready = 1'b1;
    repeat (3) tick();
    chk8("rst_txdata", TxData, 8'hBB);
    chk1("rst_valid", TxData_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_msgready", msgReady, 1'b0);
    Sys_RST = 1'b1;
    repeat (4) tick();
    chk1("static_trig_valid", TxData_valid, 1'b0);
    chk1("static_trig_busy", busy, 1'b0);

    // Basic frame with ready tied high.
    frameTrig = 1'b0;
    wait_valid("t1_start", 10);
    chk1("t1_busy", busy, 1'b1);
    check_frame("t1", exp_a);
    chk1("t1_idle_busy", busy, 1'b0);

    // Back-pressure at byte 3 for ten cycles.
    frameTrig = 1'b1;
    wait_valid("t2_start", 10);
    for (int k = 0; k < 3; k++) tick();
    TxData_ready = 1'b0;
    chk8("t2_stall_first", TxData, 8'h03);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk8($sformatf("t2_stall_data%0d", k), TxData, 8'h03);
      chk1($sformatf("t2_stall_valid%0d", k), TxData_valid, 1'b1);
    end
    TxData_ready = 1'b1;
    tick();
    chk8("t2_resume", TxData, 8'h04);
    wait_idle("t2_end", 30);

    // Message requested mid-frame waits for IDLE.
    frameTrig = 1'b0;
    wait_valid("t3_start", 10);
    msgValid = 1'b1;
    msgData  = 8'h5A;
    #1;
    for (int n = 0; n < 40 && TxData_valid === 1'b1; n++) begin
      chk1("t3_msgready_busy", msgReady, 1'b0);
      tick();
    end
    chk1("t3_frame_done", TxData_valid, 1'b0);
    chk1("t3_msgready_idle", msgReady, 1'b1);
    tick();
    chk8("t3_msg_data", TxData, 8'h5A);
    chk1("t3_msg_valid", TxData_valid, 1'b1);
    chk1("t3_msgready_after", msgReady, 1'b0);
    msgValid = 1'b0;
    msgData  = 8'h00;
    tick();
    chk1("t3_msg_done", TxData_valid, 1'b0);
    chk1("t3_msg_busy", busy, 1'b0);

    // Round-robin: first tie after reset goes to frame, next tie to message.
    Sys_RST = 1'b0;
    tick();
    Sys_RST = 1'b1;
    tick();
    frameTrig = 1'b1;
    tick();
    msgValid = 1'b1;
    msgData  = 8'hA5;
    #1;
    chk1("t4_tie1_msgready", msgReady, 1'b0);
    tick();
    chk8("t4_frame_first", TxData, 8'h05);
    // Re-trigger during the frame and change inputs; the running frame must not change.
    frameTrig    = 1'b0;
    frameCounter = 8'h33;
    framePayload = 104'h0;
    check_frame("t4", exp_a);
    chk1("t4_tie2_msgready", msgReady, 1'b1);
    chk1("t4_no_overrun", overrun, 1'b0);
    tick();
    chk8("t4_msg_second", TxData, 8'hA5);
    msgValid = 1'b0;
    tick();
    chk1("t4_msg_done", TxData_valid, 1'b0);
    wait_valid("t4_frame_third", 5);
    chk8("t4_new_counter", TxData, 8'h33);
    tick();
    chk8("t4_new_payload", TxData, 8'h00);
    wait_idle("t4_end", 30);

    // Three toggles during one frame: overrun, exactly one extra frame.
    frameCounter = 8'h05;
    framePayload = 104'h0102030405060708090A0B0C0D;
    frameTrig = 1'b1;
    wait_valid("t5_start", 10);
    tick();
    frameTrig = 1'b0;
    tick();
    frameTrig = 1'b1;
    tick();
    frameTrig = 1'b0;
    tick();
    chk1("t5_overrun_set", overrun, 1'b1);
    wait_idle("t5_first_end", 30);
    wait_valid("t5_second_start", 5);
    check_frame("t5", exp_a);
    repeat (20) tick();
    chk1("t5_no_third_valid", TxData_valid, 1'b0);
    chk1("t5_no_third_busy", busy, 1'b0);
    chk1("t5_overrun_sticky", overrun, 1'b1);

    // Counter FF with zero payload, then reset mid-frame at byte 7.
    frameCounter = 8'hFF;
    framePayload = 104'h0;
    frameTrig = 1'b1;
    wait_valid("t6_start", 10);
    check_frame("t6", exp_f);
    frameTrig = 1'b0;
    wait_valid("t6_abort_start", 10);
    for (int k = 0; k < 7; k++) tick();
    chk8("t6_byte7", TxData, 8'h00);
    Sys_RST = 1'b0;
    #1;
    chk1("t6_rst_valid", TxData_valid, 1'b0);
    chk8("t6_rst_txdata", TxData, 8'hBB);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_overrun", overrun, 1'b0);
    tick();
    Sys_RST = 1'b1;
    repeat (20) tick();
    chk1("t6_no_resume_valid", TxData_valid, 1'b0);
    chk1("t6_no_resume_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
